regfile_mp: RTL

- Parametrised multi-read-port, single-write-port register file for the pipelined MIPS datapath. Successor to the fixed 8-entry, 2-read file.
- Sits between ID (reads) and WB (write).
- Generalised in depth, data width and read-port count. Adds optional hardwired-zero register 0 and a sequenced soft-clear engine with busy/done handshake.
- Optional write-to-read bypass gives same-cycle WB→ID forwarding.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_rd_port.sv | 44 ++++
 rtl/regfile_mp.sv | 104 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
//   clr_state_e      : soft-clear sequencer states
//   clog2()          : address-width helper, usable in constant expressions
//   DEFAULT_DATA_W   : default register width, shared with the pipeline top
//   DEFAULT_NUM_REGS : default register count, shared with the pipeline top
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W   = 32;
    localparam int unsigned DEFAULT_NUM_REGS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StDone
    } clr_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file.
//   regs      in  : current array contents
//   addr      in  : read address
//   wr_accept in  : a write is being committed at the coming edge
//   wr_addr   in  : address of that write
//   wr_data   in  : data of that write
//   data      out : read data
// With REGFILE_WR_BYPASS_EN defined, an accepted write to the same address
// is forwarded in the same cycle. Register 0 still reads 0 when ZERO_REG=1.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    parameter int unsigned ADDR_W   = clog2(NUM_REGS),
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_accept,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = regs[addr];
`ifdef REGFILE_WR_BYPASS_EN
        if (wr_accept && (wr_addr == addr)) begin
            data = wr_data;
        end
`endif
        // Zero override wins over the bypass.
        if ((ZERO_REG != 0) && (addr == '0)) begin
            data = '0;
        end
    end

`ifndef REGFILE_WR_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wr_accept, wr_addr, wr_data};
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, single-write register file with sequenced soft clear.
//   clk, rst_n        : clock (rising edge), async active-low reset
//   rd_addr / rd_data : NUM_RD packed read ports, port k at slice k
//   we/wr_addr/wr_data: write port, honoured only while idle
//   clr_req           : start a sweep that zeroes one register per cycle
//   clr_busy          : sweep in progress (upstream must stall)
//   clr_done          : one-cycle pulse after the last register is cleared
// Optional macro REGFILE_WR_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned ADDR_W  = clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              wr_accept;

    assign wr_accept = we && (state_q == StIdle) && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == StSweep) begin
            regs_q[idx_q] <= '0;
        end else if (wr_accept) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StSweep;
                    idx_d   = '0;
                end
            end
            StSweep: begin
                // Leave at the last index so idx never wraps.
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign clr_busy = (state_q == StSweep);
    assign clr_done = (state_q == StDone);

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .regs      (regs_q),
            .addr      (rd_addr[k*ADDR_W +: ADDR_W]),
            .wr_accept (wr_accept),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .data      (rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule
